// File: rtl/rotate_pkg.sv
// Shared types and defaults for the rotate-buffer reader.
package rotate_pkg;

  localparam int TILE_LOG2_DEF = 6;
  localparam int PIX_W_DEF     = 32;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rot_skid_fifo.sv
// Two-entry FIFO holding {sof, eol, data} between the buffer read port and the
// output register. Head entry is presented combinationally on rd_data.
module rot_skid_fifo #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;

  // Entry storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_ptr_reg] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
      if (rd_en) rd_ptr_reg <= ~rd_ptr_reg;
      unique case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/rd_rotate_reader.sv
// Drains one TILE x TILE tile per ping-pong bank of the rotate buffer in rotated
// raster order and emits it as a valid/ready pixel stream.
// Optional build macro ROT_MIRROR_EN adds a 'mirror' input (horizontal flip after
// rotation), sampled together with rot_mode at tile start.
module rd_rotate_reader
  import rotate_pkg::*;
#(
  parameter int TILE_LOG2 = TILE_LOG2_DEF,
  parameter int PIX_W     = PIX_W_DEF
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic [1:0]           bank_rdy,
  output logic [1:0]           bank_free,
  input  logic [1:0]           rot_mode,
`ifdef ROT_MIRROR_EN
  input  logic                 mirror,
`endif
  output logic [2*TILE_LOG2:0] rd_addr,
  input  logic [PIX_W-1:0]     rd_data,
  output logic [PIX_W-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_sof,
  output logic                 m_eol,
  output logic                 busy
);

  localparam int ADDR_W = 2*TILE_LOG2 + 1;
  localparam logic [TILE_LOG2-1:0] T_IDX = '1;
  localparam int FW = PIX_W + 2;

  rd_state_e            state_reg;
  logic                 cur_bank_reg;
  rot_mode_e            mode_reg;
  logic                 mirror_reg;
  logic [TILE_LOG2-1:0] r_reg, c_reg;
  logic [1:0]           bank_free_reg;
  logic                 busy_reg;
  logic                 inflight_reg, sof_pipe_reg, eol_pipe_reg;
  logic                 out_valid_reg, out_sof_reg, out_eol_reg;
  logic [PIX_W-1:0]     out_data_reg;

  logic                 mirror_in;
  logic [1:0]           fifo_count;
  logic [FW-1:0]        fifo_head;
  logic                 fifo_pop;
  logic [2:0]           occ_next;
  logic                 issue;
  logic                 drain_done;
  logic [TILE_LOG2-1:0] c_eff, sr, sc;

`ifdef ROT_MIRROR_EN
  assign mirror_in = mirror;
`else
  assign mirror_in = 1'b0;
`endif

  // Refill the output register whenever it is empty or being consumed.
  assign fifo_pop = (fifo_count != 2'd0) && (!out_valid_reg || m_ready);

  // Occupancy the FIFO will have after this edge, counting the read landing now.
  // A new read lands one edge later, so it may issue only if this leaves a free slot.
  assign occ_next = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, fifo_pop};
  assign issue    = (state_reg == RUN) && (occ_next < 3'd2);

  assign drain_done = (state_reg == DRAIN) && !inflight_reg &&
                      (fifo_count == 2'd0) && (!out_valid_reg || m_ready);

  // Output (r,c) to source (sr,sc); mirror flips the output column first.
  always_comb begin
    c_eff = mirror_reg ? (T_IDX - c_reg) : c_reg;
    sr    = r_reg;
    sc    = c_eff;
    unique case (mode_reg)
      ROT_0:   begin sr = r_reg;         sc = c_eff;         end
      ROT_90:  begin sr = T_IDX - c_eff; sc = r_reg;         end
      ROT_180: begin sr = T_IDX - r_reg; sc = T_IDX - c_eff; end
      default: begin sr = c_eff;         sc = T_IDX - r_reg; end
    endcase
  end

  assign rd_addr = {cur_bank_reg, sr, sc};

  // Tile sequencing: wait for the current bank, walk all addresses, drain, free.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_reg     <= IDLE;
      cur_bank_reg  <= 1'b0;
      mode_reg      <= ROT_0;
      mirror_reg    <= 1'b0;
      r_reg         <= '0;
      c_reg         <= '0;
      bank_free_reg <= 2'b00;
      busy_reg      <= 1'b0;
    end else begin
      bank_free_reg <= 2'b00;
      unique case (state_reg)
        IDLE: begin
          if (bank_rdy[cur_bank_reg]) begin
            mode_reg   <= rot_mode_e'(rot_mode);
            mirror_reg <= mirror_in;
            r_reg      <= '0;
            c_reg      <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (c_reg == T_IDX) begin
              c_reg <= '0;
              if (r_reg == T_IDX) state_reg <= DRAIN;
              else                r_reg     <= r_reg + 1'b1;
            end else begin
              c_reg <= c_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            bank_free_reg[cur_bank_reg] <= 1'b1;
            cur_bank_reg <= ~cur_bank_reg;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Sideband follows its read through the one-cycle RAM latency; output register
  // holds steady until accepted.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_reg  <= 1'b0;
      sof_pipe_reg  <= 1'b0;
      eol_pipe_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      out_eol_reg   <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      inflight_reg <= issue;
      sof_pipe_reg <= issue && (r_reg == '0) && (c_reg == '0);
      eol_pipe_reg <= issue && (c_reg == T_IDX);
      if (fifo_pop) begin
        out_valid_reg <= 1'b1;
        {out_sof_reg, out_eol_reg, out_data_reg} <= fifo_head;
      end else if (m_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  rot_skid_fifo #(.W(FW)) u_skid (
    .clk     (rd_clk),
    .srst    (rd_rst),
    .wr_en   (inflight_reg),
    .wr_data ({sof_pipe_reg, eol_pipe_reg, rd_data}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  assign m_data    = out_data_reg;
  assign m_valid   = out_valid_reg;
  assign m_sof     = out_sof_reg;
  assign m_eol     = out_eol_reg;
  assign bank_free = bank_free_reg;
  assign busy      = busy_reg;

endmodule
